// File: rtl/idli_pio_m_if.sv
// idli_pio_m_if: execute-stage <-> PIO slice bus.
// master = execute stage, slave = PIO unit.
interface idli_pio_m_if;
  logic [1:0] ctr;
  logic       req;
  logic       wr;
  logic [3:0] wdata;
  logic       rdy;
  logic [3:0] rdata;
  logic       vld;

  modport master (
    output ctr, req, wr, wdata,
    input  rdy, rdata, vld
  );

  modport slave (
    input  ctr, req, wr, wdata,
    output rdy, rdata, vld
  );
endinterface

// File: rtl/idli_pio_m.sv
// idli_pio_m: 4-pin PIO, bit-serial slice access, sticky edge flags.
// Define IDLI_PIO_FALL_EN to add sticky fall flags in resp[11:8].
module idli_pio_m (
  input  logic       i_pio_gck,
  input  logic       i_pio_rst,
  input  logic [1:0] i_pio_ctr,
  input  logic       i_pio_req,
  input  logic       i_pio_wr,
  input  logic [3:0] i_pio_slice,
  output logic       o_pio_rdy,
  output logic [3:0] o_pio_slice,
  output logic       o_pio_vld,
  input  logic [3:0] i_pio_pins,
  output logic [3:0] o_pio_pins
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  word_q, word_d;
  logic [11:0] resp_q, resp_d;
  logic [3:0]  pins_q, pins_d;
  logic [3:0]  meta_q, sync_q, prev_q;
  logic [3:0]  rise_q, rise_d;
  logic [3:0]  fall_bits;
  logic [15:0] resp_w;
  logic        accept, last, commit, snap;

`ifdef IDLI_PIO_FALL_EN
  logic [3:0]  fall_q, fall_d;
`endif

  assign accept = (state_q == IDLE) && i_pio_req
                  && (i_pio_ctr == 2'd0);
  assign last   = (state_q == REQ) && i_pio_req
                  && (i_pio_ctr == 2'd3);
  assign commit = last && wr_q;
  assign snap   = last && !wr_q;

  always_ff @(posedge i_pio_gck) begin
    if (i_pio_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (!i_pio_req)
          state_d = IDLE;
        else if (i_pio_ctr == 2'd3)
          state_d = wr_q ? IDLE : RESP;
      end
      RESP: if (i_pio_ctr == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_w      = {4'h0, resp_q};
    o_pio_rdy   = (state_q == IDLE);
    o_pio_vld   = (state_q == RESP);
    o_pio_slice = 4'h0;
    if (state_q == RESP)
      o_pio_slice = resp_w[{i_pio_ctr, 2'b00} +: 4];
  end

  // A new edge in the snapshot cycle survives the clear.
  always_comb begin
    rise_d = (snap ? 4'h0 : rise_q) | (sync_q & ~prev_q);
`ifdef IDLI_PIO_FALL_EN
    fall_d = (snap ? 4'h0 : fall_q) | (~sync_q & prev_q);
    fall_bits = fall_q;
`else
    fall_bits = 4'h0;
`endif
  end

  // Only slices 0/1 (data, mask) of a write word matter.
  always_comb begin
    wr_d   = wr_q;
    word_d = word_q;
    pins_d = pins_q;
    resp_d = resp_q;
    if (accept) begin
      wr_d = i_pio_wr;
      if (i_pio_wr) word_d[3:0] = i_pio_slice;
    end
    if (state_q == REQ && i_pio_req && wr_q
        && !i_pio_ctr[1])
      word_d[{i_pio_ctr[0], 2'b00} +: 4] = i_pio_slice;
    if (commit)
      pins_d = (pins_q & ~word_q[7:4])
             | (word_q[3:0] & word_q[7:4]);
    if (snap)
      resp_d = {fall_bits, rise_q, sync_q};
  end

  always_ff @(posedge i_pio_gck) begin
    if (i_pio_rst) begin
      wr_q   <= 1'b0;
      word_q <= '0;
      resp_q <= '0;
      pins_q <= '0;
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      wr_q   <= wr_d;
      word_q <= word_d;
      resp_q <= resp_d;
      pins_q <= pins_d;
      meta_q <= i_pio_pins;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= rise_d;
    end
  end

`ifdef IDLI_PIO_FALL_EN
  always_ff @(posedge i_pio_gck) begin
    if (i_pio_rst) fall_q <= '0;
    else           fall_q <= fall_d;
  end
`endif

  assign o_pio_pins = pins_q;

endmodule

// File: tb/tb_idli_pio_m.sv
// tb_idli_pio_m: random + directed checks of idli_pio_m
// against a pin/flag-level model.
module tb_idli_pio_m;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pins_i;
  logic [3:0] pins_o;

  idli_pio_m_if bus ();

  always #5 clk = ~clk;

  idli_pio_m dut (
    .i_pio_gck  (clk),
    .i_pio_rst  (rst),
    .i_pio_ctr  (bus.ctr),
    .i_pio_req  (bus.req),
    .i_pio_wr   (bus.wr),
    .i_pio_slice(bus.wdata),
    .o_pio_rdy  (bus.rdy),
    .o_pio_slice(bus.rdata),
    .o_pio_vld  (bus.vld),
    .i_pio_pins (pins_i),
    .o_pio_pins (pins_o)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] pins_m = 4'h0;
  logic [3:0] in_m   = 4'h0;
  logic [3:0] rise_m = 4'h0;
  logic [3:0] fall_m = 4'h0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.ctr = bus.ctr + 2'd1;
    #1;
  endtask

  task automatic sync0();
    for (int i = 0; i < 4 && bus.ctr != 2'd0; i++)
      step();
  endtask

  function automatic logic [3:0] fexp();
`ifdef IDLI_PIO_FALL_EN
    return fall_m;
`else
    return 4'h0;
`endif
  endfunction

  task automatic pin_chg(input logic [3:0] p);
    rise_m |= p & ~in_m;
    fall_m |= in_m & ~p;
    in_m   = p;
    pins_i = p;
    repeat (4) step();
  endtask

  task automatic do_write(input logic [3:0] d,
                          input logic [3:0] m,
                          input int ab);
    bit live = 1'b1;
    int abx = (ab < 0) ? 4 : ab;
    sync0();
    for (int k = 0; k < 4; k++) begin
      if (k == abx) live = 1'b0;
      bus.req   = live;
      bus.wr    = 1'b1;
      bus.wdata = (k == 0) ? d : (k == 1) ? m
                : 4'($urandom);
      chk("wr_rdy", bus.rdy,
          16'((k == 0) || (k > abx)));
      step();
    end
    bus.req = 1'b0;
    if (live) pins_m = (pins_m & ~m) | (d & m);
    chk("wr_pins", pins_o, pins_m);
    chk("wr_rdy_end", bus.rdy, 1);
  endtask

  task automatic do_read(input int ab,
                         input bit chg,
                         input logic [3:0] p);
    logic [15:0] exp;
    bit live = 1'b1;
    int abx = (ab < 0) ? 4 : ab;
    sync0();
    for (int k = 0; k < 4; k++) begin
      if (k == abx) live = 1'b0;
      bus.req   = live;
      bus.wr    = 1'b0;
      bus.wdata = 4'($urandom);
      if (chg && k == 1) pins_i = p;
      chk("rd_rdy", bus.rdy,
          16'((k == 0) || (k > abx)));
      chk("rd_vld_req", bus.vld, 0);
      step();
    end
    bus.req = 1'b0;
    if (!live) begin
      chk("rd_abort_vld", bus.vld, 0);
      chk("rd_abort_rdy", bus.rdy, 1);
    end else begin
      exp = {4'h0, fexp(), rise_m, chg ? p : in_m};
      rise_m = 4'h0;
      fall_m = 4'h0;
      if (chg) begin
        rise_m = p & ~in_m;
        fall_m = in_m & ~p;
        in_m   = p;
      end
      for (int k = 0; k < 4; k++) begin
        bus.req = 1'($urandom);
        bus.wr  = 1'($urandom);
        chk("rd_vld", bus.vld, 1);
        chk("rd_slice", bus.rdata, exp[4*k +: 4]);
        chk("rd_rdy_resp", bus.rdy, 0);
        step();
      end
      bus.req = 1'b0;
      chk("rd_vld_end", bus.vld, 0);
      chk("rd_slice_end", bus.rdata, 0);
      chk("rd_rdy_end", bus.rdy, 1);
    end
  endtask

  task automatic ignore_test();
    sync0();
    step();
    bus.req   = 1'b1;
    bus.wr    = 1'b1;
    bus.wdata = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) bus.req = 1'b0;
      chk("ign_rdy", bus.rdy, 1);
    end
    step();
    chk("ign_pins", pins_o, pins_m);
  endtask

  initial begin
    rst       = 1'b1;
    bus.ctr   = 2'd0;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.wdata = 4'h0;
    pins_i    = 4'h0;
    repeat (3) step();
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_vld", bus.vld, 0);
    chk("rst_slice", bus.rdata, 0);
    chk("rst_pins", pins_o, 0);
    rst = 1'b0;
    repeat (3) step();

    do_write(4'h5, 4'hF, -1);
    chk("dir_wr1", pins_o, 16'h5);
    do_write(4'hA, 4'h3, -1);
    chk("dir_wr2", pins_o, 16'h6);

    pin_chg(4'h9);
    do_read(-1, 1'b0, 4'h0);
    do_read(-1, 1'b0, 4'h0);

    pin_chg(4'hF);
    do_read(-1, 1'b0, 4'h0);
    pin_chg(4'h0);
    do_read(-1, 1'b0, 4'h0);

    do_write(4'h0, 4'hF, 2);
    chk("abort_pins", pins_o, 16'h6);
    do_write(4'h3, 4'hF, -1);
    chk("after_abort", pins_o, 16'h3);

    ignore_test();

    pin_chg(4'h1);
    do_read(2, 1'b0, 4'h0);
    do_read(-1, 1'b0, 4'h0);

    pin_chg(4'h0);
    do_read(-1, 1'b0, 4'h0);
    do_read(-1, 1'b1, 4'h1);
    do_read(-1, 1'b0, 4'h0);

    for (int i = 0; i < 60; i++) begin
      int op = int'($urandom_range(0, 4));
      int ab = ($urandom_range(0, 3) == 0)
             ? int'($urandom_range(1, 3)) : -1;
      case (op)
        0: pin_chg(4'($urandom));
        1: do_write(4'($urandom), 4'($urandom), ab);
        2: do_read(ab, 1'b0, 4'h0);
        3: do_read(-1, 1'b1, 4'($urandom));
        default: ignore_test();
      endcase
    end

    pin_chg(4'h0);
    sync0();
    for (int k = 0; k < 4; k++) begin
      bus.req = 1'b1;
      bus.wr  = 1'b0;
      step();
    end
    bus.req = 1'b0;
    chk("rr_vld_on", bus.vld, 1);
    step();
    rst = 1'b1;
    step();
    chk("rr_vld", bus.vld, 0);
    chk("rr_slice", bus.rdata, 0);
    chk("rr_pins", pins_o, 0);
    chk("rr_rdy", bus.rdy, 1);
    rst    = 1'b0;
    pins_m = 4'h0;
    rise_m = 4'h0;
    fall_m = 4'h0;
    step();
    do_read(-1, 1'b0, 4'h0);
    do_write(4'hC, 4'hE, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
